// File: rtl/mlops_pkg.sv
// mlops_pkg: element and chunk types shared by the mlops datapath blocks.
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

package mlops_pkg;

  localparam int NBits              = 8;
  localparam int WorkingRegsDefault = 4;

  typedef logic signed [NBits-1:0]      elem_t;
  typedef elem_t [WorkingRegsDefault-1:0] chunk_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

`default_nettype wire

// File: rtl/v_chunk_ram.sv
// v_chunk_ram: simple dual-port chunk store, one write port, registered read port.
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module v_chunk_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_in,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Read register only loads on a request, so the output holds between reads.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/v_chunk_fifo.sv
// v_chunk_fifo: chunk-granular FIFO that tracks whole vectors for a downstream op.
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module v_chunk_fifo
  import mlops_pkg::*;
#(
  parameter int InVecLength = 16,
  parameter int WorkingRegs = 4,
  parameter int DepthChunks = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     wr_chunk,
  input  elem_t [WorkingRegs-1:0]  wr_data,
  input  logic                     rd_chunk,
  output elem_t [WorkingRegs-1:0]  rd_data,
  output logic                     vec_ready,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int CHUNKS_PER_VEC = ceil_div(InVecLength, WorkingRegs);
  localparam int AW    = (DepthChunks > 1) ? $clog2(DepthChunks) : 1;
  localparam int CW    = $clog2(DepthChunks + 1);
  localparam int SW    = (CHUNKS_PER_VEC > 1) ? $clog2(CHUNKS_PER_VEC) : 1;
  localparam int WIDTH = WorkingRegs * NBits;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] wr_sub_q, wr_sub_d, rd_sub_q, rd_sub_d;
  logic [CW-1:0] chunk_count_q, chunk_count_d;
  logic [CW-1:0] vec_count_q, vec_count_d;
  logic          overflow_q, overflow_d;
  logic          full_q, full_d, empty_q, empty_d, vec_ready_q, vec_ready_d;
  logic          rd_zero_q, rd_zero_d;
  logic          wr_accept, rd_accept, wr_vec_done, rd_vec_done;
  logic [WIDTH-1:0] ram_rd_data;

  always_comb begin
    rd_accept     = rst_in && rd_chunk && !empty_q;
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    wr_accept     = rst_in && wr_chunk && (!full_q || rd_accept);
    wr_vec_done   = wr_accept && (wr_sub_q == SW'(CHUNKS_PER_VEC - 1));
    rd_vec_done   = rd_accept && (rd_sub_q == SW'(CHUNKS_PER_VEC - 1));

    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_sub_d      = wr_sub_q;
    rd_sub_d      = rd_sub_q;
    chunk_count_d = chunk_count_q;
    vec_count_d   = vec_count_q;
    overflow_d    = overflow_q;
    rd_zero_d     = rd_zero_q;

    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == AW'(DepthChunks - 1)) ? '0 : wr_ptr_q + AW'(1);
      wr_sub_d = wr_vec_done ? '0 : wr_sub_q + SW'(1);
    end else if (rst_in && wr_chunk) begin
      overflow_d = 1'b1;
    end

    if (rd_accept) begin
      rd_ptr_d  = (rd_ptr_q == AW'(DepthChunks - 1)) ? '0 : rd_ptr_q + AW'(1);
      rd_sub_d  = rd_vec_done ? '0 : rd_sub_q + SW'(1);
      rd_zero_d = 1'b0;
    end

    case ({wr_accept, rd_accept})
      2'b10:   chunk_count_d = chunk_count_q + CW'(1);
      2'b01:   chunk_count_d = chunk_count_q - CW'(1);
      default: chunk_count_d = chunk_count_q;
    endcase

    case ({wr_vec_done, rd_vec_done})
      2'b10:   vec_count_d = vec_count_q + CW'(1);
      2'b01:   vec_count_d = vec_count_q - CW'(1);
      default: vec_count_d = vec_count_q;
    endcase

    full_d      = (chunk_count_d == CW'(DepthChunks));
    empty_d     = (chunk_count_d == '0);
    vec_ready_d = (vec_count_d != '0);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wr_sub_q      <= '0;
      rd_sub_q      <= '0;
      chunk_count_q <= '0;
      vec_count_q   <= '0;
      overflow_q    <= 1'b0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      vec_ready_q   <= 1'b0;
      rd_zero_q     <= 1'b1;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_sub_q      <= wr_sub_d;
      rd_sub_q      <= rd_sub_d;
      chunk_count_q <= chunk_count_d;
      vec_count_q   <= vec_count_d;
      overflow_q    <= overflow_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      vec_ready_q   <= vec_ready_d;
      rd_zero_q     <= rd_zero_d;
    end
  end

  v_chunk_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DepthChunks),
    .AW    (AW)
  ) u_ram (
    .clk_in  (clk_in),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  // The RAM read register has no reset; mask it to zero until the first read.
  assign rd_data   = rd_zero_q ? '0 : ram_rd_data;
  assign vec_ready = vec_ready_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_v_chunk_fifo.sv
// tb_v_chunk_fifo: directed scoreboard bench for v_chunk_fifo (default parameters).
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module tb_v_chunk_fifo;

  localparam int DEPTH = 16;
  localparam int CPV   = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        wr_chunk = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_chunk = 1'b0;
  logic [31:0] rd_data;
  logic        vec_ready, full, empty, overflow;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb [$];
  logic [31:0] exp_rd;
  int          m_count, m_wsub, m_rsub, m_vec;
  bit          m_ovf;

  v_chunk_fifo #(
    .InVecLength (16),
    .WorkingRegs (4),
    .DepthChunks (DEPTH)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .wr_chunk  (wr_chunk),
    .wr_data   (wr_data),
    .rd_chunk  (rd_chunk),
    .rd_data   (rd_data),
    .vec_ready (vec_ready),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mk(input int base);
    logic [7:0] b;
    b = base[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".rd_data"},   rd_data,          exp_rd);
    check({tag, ".full"},      {31'd0, full},     {31'd0, m_count == DEPTH});
    check({tag, ".empty"},     {31'd0, empty},    {31'd0, m_count == 0});
    check({tag, ".vec_ready"}, {31'd0, vec_ready}, {31'd0, m_vec != 0});
    check({tag, ".overflow"},  {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  // One clock with the given strobes; the bench model decides what is accepted.
  task automatic step(input string tag, input bit wr, input logic [31:0] d, input bit rd);
    bit ra, wa;
    ra = rd && (m_count != 0);
    wa = wr && ((m_count != DEPTH) || ra);
    if (ra) begin
      exp_rd = sb.pop_front();
      if (m_rsub == CPV - 1) begin m_rsub = 0; m_vec--; end
      else m_rsub++;
    end
    if (wa) begin
      sb.push_back(d);
      if (m_wsub == CPV - 1) begin m_wsub = 0; m_vec++; end
      else m_wsub++;
    end
    if (wr && !wa) m_ovf = 1'b1;
    m_count = m_count + int'(wa) - int'(ra);
    wr_chunk = wr;
    wr_data  = d;
    rd_chunk = rd;
    @(posedge clk_in); #1;
    wr_chunk = 1'b0;
    rd_chunk = 1'b0;
    check_flags(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_in   = 1'b0;
    wr_chunk = 1'b1;
    wr_data  = 32'hDEAD_BEEF;
    rd_chunk = 1'b1;
    @(posedge clk_in); #1;
    rst_in   = 1'b1;
    wr_chunk = 1'b0;
    rd_chunk = 1'b0;
    sb.delete();
    exp_rd  = '0;
    m_count = 0; m_wsub = 0; m_rsub = 0; m_vec = 0; m_ovf = 1'b0;
    check_flags(tag);
  endtask

  initial begin
    @(posedge clk_in); #1;
    do_reset("reset");

    for (int i = 0; i < 4; i++) step("wr_vec", 1'b1, mk(1 + 4 * i), 1'b0);
    for (int i = 0; i < 4; i++) step("rd_vec", 1'b0, '0, 1'b1);
    check("rd_last_chunk", rd_data, 32'h100F0E0D);

    step("rd_empty0", 1'b0, '0, 1'b1);
    step("rd_empty1", 1'b0, '0, 1'b1);

    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, mk(32 + 4 * i), 1'b0);
    step("overflow_wr", 1'b1, mk(200), 1'b0);
    step("full_rdwr", 1'b1, mk(220), 1'b1);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1);
    step("drain_empty", 1'b0, '0, 1'b1);

    step("prime0", 1'b1, mk(2), 1'b0);
    step("prime1", 1'b1, mk(6), 1'b0);
    for (int i = 0; i < 40; i++) step("stream", 1'b1, mk(10 + 3 * i), 1'b1);
    step("stream_tail0", 1'b0, '0, 1'b1);
    step("stream_tail1", 1'b0, '0, 1'b1);

    step("pre_rst0", 1'b1, mk(70), 1'b0);
    step("pre_rst1", 1'b1, mk(74), 1'b0);
    do_reset("mid_reset");
    for (int i = 0; i < 4; i++) step("rebuild", 1'b1, mk(90 + 4 * i), 1'b0);
    for (int i = 0; i < 4; i++) step("rebuild_rd", 1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
